// File: rtl/mod_vumeter_ballistics.sv
`default_nettype none
// ============================================================================
// Module      : mod_vumeter_ballistics
// Description : VU meter ballistics stage. Instant attack, timed linear bar
//               decay and a peak-hold marker that holds and then falls, all
//               paced by a free-running tick prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_vumeter_ballistics #(
  parameter int QUANTIZATION_COUNT = 16,
  parameter int TICK_DIV           = 1048576,
  parameter int DECAY_TICKS        = 4,
  parameter int HOLD_TICKS         = 24
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [QUANTIZATION_COUNT-1:0]         i_led_amps,
  input  logic                                  i_valid,
  output logic [QUANTIZATION_COUNT-1:0]         o_led_bar,
  output logic [QUANTIZATION_COUNT-1:0]         o_peak_led,
  output logic [$clog2(QUANTIZATION_COUNT+1)-1:0] o_level
);

  localparam int LW = $clog2(QUANTIZATION_COUNT + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEC_MAX   = DW'(DECAY_TICKS - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_TICKS);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FALL = 2'd2
  } peak_state_t;

  logic [PW-1:0] prescaler;
  logic          tick;
  logic [LW-1:0] inst;

  logic [LW-1:0] bar_level, bar_next;
  logic [DW-1:0] bar_cnt, bar_cnt_next;

  peak_state_t   state, state_next;
  logic [LW-1:0] peak_level, peak_next;
  logic [HW-1:0] hold_cnt, hold_next;
  logic [DW-1:0] fall_cnt, fall_next;

  logic [QUANTIZATION_COUNT-1:0] bar_vec_next;
  logic [QUANTIZATION_COUNT-1:0] peak_vec_next;

  assign tick    = (prescaler == PRE_MAX);
  assign o_level = bar_level;

  // Instantaneous level: position of the highest set bit, plus one.
  always_comb begin
    inst = '0;
    for (int i = 0; i < QUANTIZATION_COUNT; i++) begin
      if (i_led_amps[i]) begin
        inst = LW'(i + 1);
      end
    end
  end

  // Bar: attack wins over a same-cycle tick; otherwise decay one segment per DECAY_TICKS ticks.
  always_comb begin
    bar_next     = bar_level;
    bar_cnt_next = bar_cnt;
    if (i_valid && (inst >= bar_level)) begin
      bar_next     = inst;
      bar_cnt_next = '0;
    end else if (bar_level == '0) begin
      bar_cnt_next = '0;
    end else if (tick) begin
      if (bar_cnt == DEC_MAX) begin
        bar_next     = bar_level - LVL_ONE;
        bar_cnt_next = '0;
      end else begin
        bar_cnt_next = bar_cnt + DW'(1);
      end
    end
  end

  // Peak FSM next state: capture on qualifying sample, hold, then fall back onto the bar.
  always_comb begin
    state_next = state;
    peak_next  = peak_level;
    hold_next  = hold_cnt;
    fall_next  = fall_cnt;
    if (i_valid && (inst != '0) && (inst >= peak_level)) begin
      peak_next  = inst;
      hold_next  = HOLD_INIT;
      fall_next  = '0;
      state_next = HOLD;
    end else if (tick) begin
      case (state)
        HOLD: begin
          if (hold_cnt != '0) begin
            hold_next = hold_cnt - HW'(1);
          end else begin
            state_next = FALL;
            fall_next  = '0;
          end
        end
        FALL: begin
          if (fall_cnt == DEC_MAX) begin
            fall_next = '0;
            // Landing on the bar: the marker never goes below it.
            if ((peak_level <= bar_level) || ((peak_level - LVL_ONE) <= bar_level)) begin
              peak_next  = bar_level;
              hold_next  = '0;
              state_next = (bar_level == '0) ? IDLE : HOLD;
            end else begin
              peak_next = peak_level - LVL_ONE;
            end
          end else begin
            fall_next = fall_cnt + DW'(1);
          end
        end
        default: begin
          state_next = IDLE;
          peak_next  = '0;
        end
      endcase
    end
  end

  // Output decode of the next levels so the LED vectors are registered alongside the levels.
  for (genvar i = 0; i < QUANTIZATION_COUNT; i++) begin : g_decode
    assign bar_vec_next[i]  = (LW'(i) < bar_next);
    assign peak_vec_next[i] = (peak_next == LW'(i + 1));
  end

  // State registers with asynchronous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prescaler  <= '0;
      bar_level  <= '0;
      bar_cnt    <= '0;
      state      <= IDLE;
      peak_level <= '0;
      hold_cnt   <= '0;
      fall_cnt   <= '0;
      o_led_bar  <= '0;
      o_peak_led <= '0;
    end else begin
      prescaler  <= tick ? '0 : (prescaler + PW'(1));
      bar_level  <= bar_next;
      bar_cnt    <= bar_cnt_next;
      state      <= state_next;
      peak_level <= peak_next;
      hold_cnt   <= hold_next;
      fall_cnt   <= fall_next;
      o_led_bar  <= bar_vec_next;
      o_peak_led <= peak_vec_next;
    end
  end

endmodule
`default_nettype wire
